// File: rtl/ram_dp_bytewrite_pipe.sv
// True dual-port byte-writable RAM with selectable read-during-write mode and optional output register.
// Latency 1+OUT_REG, one access per port per cycle, no stalls; RAM_COLLISION_DETECT_EN enables the collision pulse.
module ram_dp_bytewrite_pipe #(
    parameter int RAM_DEPTH = 16384,
    parameter int COL_WIDTH = 8,
    parameter int COL_NUM   = 4,
    parameter int READ_MODE = 0,
    parameter int OUT_REG   = 0,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int W  = COL_NUM * COL_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      addra,
    input  logic [W-1:0]       dina,
    input  logic               ena,
    input  logic [COL_NUM-1:0] wea,
    output logic [W-1:0]       douta,
    output logic               rvalida,
    input  logic [AW-1:0]      addrb,
    input  logic [W-1:0]       dinb,
    input  logic               enb,
    input  logic [COL_NUM-1:0] web,
    output logic [W-1:0]       doutb,
    output logic               rvalidb,
    output logic               collision
);

    logic [W-1:0] mem_q [RAM_DEPTH];

    logic [W-1:0] rd_a_d, rd_b_d;
    logic         vld_a_d, vld_b_d;
    logic [W-1:0] dout1_a_q, dout1_b_q;
    logic         vld1_a_q, vld1_b_q;

    // Port A is applied last so it wins a same-column, same-address write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < COL_NUM; i++) begin
                if (enb && web[i]) begin
                    mem_q[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
                end
                if (ena && wea[i]) begin
                    mem_q[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // Write-first columns return the value the array will hold after this edge.
    always_comb begin
        rd_a_d = mem_q[addra];
        rd_b_d = mem_q[addrb];
        if (READ_MODE == 0) begin
            for (int i = 0; i < COL_NUM; i++) begin
                if (wea[i]) begin
                    rd_a_d[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
                end
                if (web[i]) begin
                    rd_b_d[i*COL_WIDTH +: COL_WIDTH] = (ena && wea[i] && (addra == addrb)) ?
                        dina[i*COL_WIDTH +: COL_WIDTH] : dinb[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    assign vld_a_d = ena && ((READ_MODE != 2) || (wea == '0));
    assign vld_b_d = enb && ((READ_MODE != 2) || (web == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            dout1_a_q <= '0;
            dout1_b_q <= '0;
            vld1_a_q  <= 1'b0;
            vld1_b_q  <= 1'b0;
        end else begin
            vld1_a_q <= vld_a_d;
            vld1_b_q <= vld_b_d;
            if (vld_a_d) begin
                dout1_a_q <= rd_a_d;
            end
            if (vld_b_d) begin
                dout1_b_q <= rd_b_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [W-1:0] dout2_a_q, dout2_b_q;
            logic         vld2_a_q, vld2_b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout2_a_q <= '0;
                    dout2_b_q <= '0;
                    vld2_a_q  <= 1'b0;
                    vld2_b_q  <= 1'b0;
                end else begin
                    vld2_a_q <= vld1_a_q;
                    vld2_b_q <= vld1_b_q;
                    if (vld1_a_q) begin
                        dout2_a_q <= dout1_a_q;
                    end
                    if (vld1_b_q) begin
                        dout2_b_q <= dout1_b_q;
                    end
                end
            end

            assign douta   = dout2_a_q;
            assign doutb   = dout2_b_q;
            assign rvalida = vld2_a_q;
            assign rvalidb = vld2_b_q;
        end else begin : g_noreg
            assign douta   = dout1_a_q;
            assign doutb   = dout1_b_q;
            assign rvalida = vld1_a_q;
            assign rvalidb = vld1_b_q;
        end
    endgenerate

`ifdef RAM_COLLISION_DETECT_EN
    logic coll_d, coll_q;

    assign coll_d = ena && enb && (addra == addrb) && ((wea != '0) || (web != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;

    always_ff @(posedge clk) begin
        if (!reset && ena && enb && (addra == addrb)) begin
            assert ((wea & web) == '0)
                else $error("ram_dp_bytewrite_pipe: write-write column overlap at addr %0d", addra);
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dp_bytewrite_pipe.sv
// Bench for ram_dp_bytewrite_pipe: three configurations share stimulus; a queue scoreboard checks every cycle.
module tb_ram_dp_bytewrite_pipe;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NI    = 3;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] addra, addrb;
    logic [31:0]   dina, dinb;
    logic          ena, enb;
    logic [3:0]    wea, web;

    logic [31:0] douta_w [NI];
    logic [31:0] doutb_w [NI];
    logic        rvalida_w [NI];
    logic        rvalidb_w [NI];
    logic        coll_w [NI];

    // Instance g: READ_MODE = g; instance 1 also carries the output register.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_dp_bytewrite_pipe #(
            .RAM_DEPTH(DEPTH), .COL_WIDTH(8), .COL_NUM(4),
            .READ_MODE(g), .OUT_REG((g == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset(reset),
            .addra(addra), .dina(dina), .ena(ena), .wea(wea),
            .douta(douta_w[g]), .rvalida(rvalida_w[g]),
            .addrb(addrb), .dinb(dinb), .enb(enb), .web(web),
            .doutb(doutb_w[g]), .rvalidb(rvalidb_w[g]),
            .collision(coll_w[g])
        );
    end

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        rst_edge = 1'b0;
    logic        exp_coll = 1'b0;
    logic [31:0] mem_m [DEPTH];
    exp_t        sbq [2*NI][$];
    logic [31:0] last_m [2*NI];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endfunction

    function automatic void push_exp(int g, int p, logic [3:0] we, logic [31:0] pre, logic [31:0] post);
        logic [31:0] d;
        exp_t        e;
        if (g == 2 && we != 4'h0) return;
        d = pre;
        if (g == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) d[i*8 +: 8] = post[i*8 +: 8];
            end
        end
        e.due  = cyc + ((g == 1) ? 1 : 0);
        e.data = d;
        sbq[g*2+p].push_back(e);
    endfunction

    // Reference model: an array of words updated at each edge from the current inputs.
    always @(posedge clk) begin : model
        logic [31:0] pre_a, pre_b, post_a, post_b;
        cyc++;
        rst_edge = reset;
        exp_coll = 1'b0;
        if (reset) begin
            for (int k = 0; k < 2*NI; k++) sbq[k].delete();
        end else begin
            pre_a = mem_m[addra];
            pre_b = mem_m[addrb];
            for (int i = 0; i < 4; i++) begin
                if (enb && web[i]) mem_m[addrb][i*8 +: 8] = dinb[i*8 +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                if (ena && wea[i]) mem_m[addra][i*8 +: 8] = dina[i*8 +: 8];
            end
            post_a = mem_m[addra];
            post_b = mem_m[addrb];
`ifdef RAM_COLLISION_DETECT_EN
            exp_coll = ena && enb && (addra == addrb) && ((wea != 4'h0) || (web != 4'h0));
`endif
            for (int g = 0; g < NI; g++) begin
                if (ena) push_exp(g, 0, wea, pre_a, post_a);
                if (enb) push_exp(g, 1, web, pre_b, post_b);
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic        v;
        logic [31:0] d;
        exp_t        e;
        if (cyc > 0) begin
            for (int k = 0; k < 2*NI; k++) begin
                v = (k % 2 == 0) ? rvalida_w[k/2] : rvalidb_w[k/2];
                d = (k % 2 == 0) ? douta_w[k/2]   : doutb_w[k/2];
                if (rst_edge) last_m[k] = 32'h0;
                if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
                    e = sbq[k].pop_front();
                    last_m[k] = e.data;
                    chk($sformatf("rvalid inst%0d port%0d", k/2, k%2), {31'h0, v}, 32'h1);
                end else begin
                    chk($sformatf("rvalid inst%0d port%0d", k/2, k%2), {31'h0, v}, 32'h0);
                end
                chk($sformatf("dout inst%0d port%0d", k/2, k%2), d, last_m[k]);
            end
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("collision inst%0d", g), {31'h0, coll_w[g]}, {31'h0, exp_coll});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    endtask

    task automatic set_a(logic [AW-1:0] a, logic [3:0] we, logic [31:0] d);
        ena = 1'b1; addra = a; wea = we; dina = d;
    endtask

    task automatic set_b(logic [AW-1:0] a, logic [3:0] we, logic [31:0] d);
        enb = 1'b1; addrb = a; web = we; dinb = d;
    endtask

    initial begin
        logic coll_exp;
        reset = 1'b1;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
        idle();
        repeat (3) tick();
        reset = 1'b0;

        for (int a = 0; a < DEPTH/2; a++) begin
            set_a(AW'(2*a), 4'hF, 32'hA500_0000 | (2*a));
            set_b(AW'(2*a+1), 4'hF, 32'hA500_0000 | (2*a+1));
            tick();
        end
        idle();
        tick();

        set_a(5, 4'hF, 32'hDEADBEEF); tick();
        set_a(5, 4'h0, 32'h0); tick(); idle();
        @(negedge clk);
        chk("direct read5 data", douta_w[0], 32'hDEADBEEF);
        chk("direct read5 valid", {31'h0, rvalida_w[0]}, 32'h1);

        set_b(7, 4'hF, 32'h11223344); tick();
        set_b(7, 4'b0101, 32'hAABBCCDD); tick();
        set_b(7, 4'h0, 32'h0); tick(); idle();
        @(negedge clk);
        chk("direct bytewrite", doutb_w[0], 32'h11BB33DD);

        set_a(3, 4'hF, 32'h0); tick();
        set_a(3, 4'hF, 32'h12345678); tick(); idle();
        @(negedge clk);
        chk("rdw write_first", douta_w[0], 32'h12345678);
        chk("rdw no_change hold", douta_w[2], 32'hDEADBEEF);
        chk("rdw no_change valid", {31'h0, rvalida_w[2]}, 32'h0);
        @(negedge clk);
        chk("rdw read_first", douta_w[1], 32'h0);

        set_a(9, 4'hF, 32'hAAAAAAAA);
        set_b(9, 4'hF, 32'h55555555);
        tick(); idle();
`ifdef RAM_COLLISION_DETECT_EN
        coll_exp = 1'b1;
`else
        coll_exp = 1'b0;
`endif
        @(negedge clk);
        chk("direct collision pulse", {31'h0, coll_w[0]}, {31'h0, coll_exp});
        @(negedge clk);
        chk("direct collision end", {31'h0, coll_w[0]}, 32'h0);
        set_a(9, 4'h0, 32'h0); tick(); idle();
        @(negedge clk);
        chk("direct a wins", douta_w[0], 32'hAAAAAAAA);

        for (int a = 0; a < 3; a++) begin
            set_b(AW'(a), 4'h0, 32'h0); tick();
        end
        idle();
        repeat (3) tick();
        set_b(0, 4'h0, 32'h0); tick();
        reset = 1'b1;
        set_b(1, 4'h0, 32'h0); tick();
        set_b(2, 4'h0, 32'h0); tick();
        reset = 1'b0; idle();
        repeat (3) tick();

        reset = 1'b1;
        set_a(4, 4'hF, 32'hFFFFFFFF);
        repeat (3) tick();
        reset = 1'b0; idle(); tick();
        set_a(4, 4'h0, 32'h0); tick(); idle();
        @(negedge clk);
        chk("reset blocks write", douta_w[0], 32'hA500_0004);

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(63) == 0);
            ena   = ($urandom_range(3) != 0);
            enb   = ($urandom_range(3) != 0);
            addra = AW'($urandom_range(15));
            addrb = AW'($urandom_range(15));
            dina  = $urandom;
            dinb  = $urandom;
            wea   = $urandom_range(1) ? 4'($urandom) : 4'h0;
            web   = $urandom_range(1) ? 4'($urandom) : 4'h0;
`ifdef RAM_COLLISION_DETECT_EN
            if (addra == addrb) web = web & ~wea;
`endif
            tick();
        end
        reset = 1'b0; idle();
        repeat (4) tick();
        @(negedge clk);
        for (int k = 0; k < 2*NI; k++) begin
            chk($sformatf("drained inst%0d port%0d", k/2, k%2), sbq[k].size(), 32'h0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
